// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x3 phone-style matrix keypad one column at a time,
// debounces whole scan frames and emits exactly one single-cycle key code
// strobe per physical press.
module keypad_scan #(
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    output logic [3:0] keypad_out,
    output logic       key_valid
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED
    } state_t;

    state_t        state, state_next;
    logic [3:0]    row_meta, row_sync;
    logic [SW-1:0] slot_cnt;
    logic [1:0]    col_idx;
    logic          sample_now;
    logic [1:0]    col_hits;
    logic [3:0]    col_code;
    logic [1:0]    acc_hits, hits_sum;
    logic [3:0]    acc_code;
    logic          eval;
    logic          frame_key;
    logic [3:0]    code_q, code_next;
    logic [CW-1:0] deb_q, deb_next;
    logic [CW-1:0] rel_q, rel_next;
    logic          emit;

    // Two-flop synchronizer; idles high because the rows are pulled up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    assign sample_now = (slot_cnt == SLOT_LAST);

    // Slot and column counters: rows are sampled in the last slot of each column.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt <= '0;
            col_idx  <= 2'd0;
        end else if (sample_now) begin
            slot_cnt <= '0;
            col_idx  <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + SW'(1);
        end
    end

    // Active-low one-hot column drive decoded from the column index.
    always_comb begin
        case (col_idx)
            2'd0:    col_out = 3'b110;
            2'd1:    col_out = 3'b101;
            2'd2:    col_out = 3'b011;
            default: col_out = 3'b110;
        endcase
    end

    // Per-column decode: how many rows are low (saturating at 2) and the key code.
    always_comb begin
        col_hits = 2'd0;
        col_code = 4'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync[r]) begin
                col_code = 4'(r * 3 + int'(col_idx) + 1);
            end
        end
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r] && (col_hits != 2'd2)) begin
                col_hits = col_hits + 2'd1;
            end
        end
    end

    // Saturating sum of keys seen so far in the current frame plus this column.
    always_comb begin
        logic [2:0] sum;
        sum      = {1'b0, acc_hits} + {1'b0, col_hits};
        hits_sum = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    end

    // Frame accumulator; column 0 starts a fresh frame, eval fires after column 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_hits <= 2'd0;
            acc_code <= 4'd0;
            eval     <= 1'b0;
        end else begin
            eval <= sample_now && (col_idx == 2'd2);
            if (sample_now) begin
                if (col_idx == 2'd0) begin
                    acc_hits <= col_hits;
                    acc_code <= col_code;
                end else begin
                    acc_hits <= hits_sum;
                    if (col_hits != 2'd0) begin
                        acc_code <= col_code;
                    end
                end
            end
        end
    end

    assign frame_key = (acc_hits == 2'd1);

    // FSM state, latched code and debounce/release counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            code_q <= 4'd0;
            deb_q  <= '0;
            rel_q  <= '0;
        end else begin
            state  <= state_next;
            code_q <= code_next;
            deb_q  <= deb_next;
            rel_q  <= rel_next;
        end
    end

    // Next-state logic; only acts on frame-evaluation cycles, MULTI counts as NONE.
    always_comb begin
        state_next = state;
        code_next  = code_q;
        deb_next   = deb_q;
        rel_next   = rel_q;
        emit       = 1'b0;
        if (eval) begin
            case (state)
                ST_IDLE: begin
                    if (frame_key) begin
                        code_next = acc_code;
                        deb_next  = CW'(1);
                        if (DEBOUNCE == 1) begin
                            emit       = 1'b1;
                            rel_next   = '0;
                            state_next = ST_PRESSED;
                        end else begin
                            state_next = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame_key) begin
                        if (acc_code == code_q) begin
                            if (deb_q != CNT_TARGET) begin
                                deb_next = deb_q + CW'(1);
                            end
                            if (deb_q >= CNT_LAST) begin
                                emit       = 1'b1;
                                rel_next   = '0;
                                state_next = ST_PRESSED;
                            end
                        end else begin
                            code_next = acc_code;
                            deb_next  = CW'(1);
                        end
                    end else begin
                        deb_next   = '0;
                        state_next = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (frame_key) begin
                        rel_next = '0;
                    end else if (rel_q >= CNT_LAST) begin
                        rel_next   = '0;
                        deb_next   = '0;
                        state_next = ST_IDLE;
                    end else begin
                        rel_next = rel_q + CW'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    deb_next   = '0;
                    rel_next   = '0;
                end
            endcase
        end
    end

    // Registered one-cycle strobe carrying the accepted code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_valid  <= 1'b0;
            keypad_out <= 4'd0;
        end else begin
            key_valid  <= emit;
            keypad_out <= emit ? code_next : 4'd0;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: drives a modelled 4x3 key matrix and scoreboards the
// expected key strobes against keypad_scan (SCAN_DIV=4, DEBOUNCE=2).
module tb_keypad_scan;

    localparam int SCAN_DIV  = 4;
    localparam int DEBOUNCE  = 2;
    localparam int FRAME     = 3 * SCAN_DIV;
    localparam int LAT_LIMIT = (DEBOUNCE + 1) * FRAME + 3;

    logic       clk;
    logic       rst;
    logic [3:0] row_in;
    logic [2:0] col_out;
    logic [3:0] keypad_out;
    logic       key_valid;

    logic [11:0] keys_held;
    logic [3:0]  exp_q[$];
    int          checks;
    int          errors;
    int          strobe_count;

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_in     (row_in),
        .col_out    (col_out),
        .keypad_out (keypad_out),
        .key_valid  (key_valid)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Key matrix model: a held key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (keys_held[r * 3 + c] && (col_out[c] == 1'b0)) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every strobe must match the next expected code, otherwise the output is zero.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            strobe_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_strobe: got keypad_out=%b, required no strobe", keypad_out);
            end else begin
                logic [3:0] exp_code;
                exp_code = exp_q.pop_front();
                if (keypad_out !== exp_code) begin
                    errors++;
                    $display("[TB] FAIL strobe_code: got %b, required %b", keypad_out, exp_code);
                end
            end
        end else begin
            checks++;
            if (keypad_out !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL idle_output: got keypad_out=%b key_valid=%b, required 0000", keypad_out, key_valid);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Waits until strobe_count moves past start or the bound expires; n is cycles spent.
    task automatic wait_for_strobe(input int start, input int bound, output int n);
        n = 0;
        while ((strobe_count == start) && (n < bound)) begin
            step(1);
            n++;
        end
    endtask

    task automatic test_reset;
        rst       = 1'b0;
        keys_held = '0;
        #3;
        checks++;
        if ((col_out !== 3'b110) || (key_valid !== 1'b0) || (keypad_out !== 4'b0000)) begin
            errors++;
            $display("[TB] FAIL reset_values: got col=%b valid=%b out=%b, required 110/0/0000",
                     col_out, key_valid, keypad_out);
        end
        step(3);
        checks++;
        if (col_out !== 3'b110) begin
            errors++;
            $display("[TB] FAIL reset_hold_col: got %b, required 110", col_out);
        end
    endtask

    task automatic test_idle_scan;
        logic [2:0] exp_col;
        int         start;
        @(negedge clk);
        rst   = 1'b1;
        start = strobe_count;
        for (int k = 0; k < 5 * FRAME; k++) begin
            case ((k / SCAN_DIV) % 3)
                0:       exp_col = 3'b110;
                1:       exp_col = 3'b101;
                default: exp_col = 3'b011;
            endcase
            #1;
            checks++;
            if (col_out !== exp_col) begin
                errors++;
                $display("[TB] FAIL scan_col k=%0d: got %b, required %b", k, col_out, exp_col);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (strobe_count != start) begin
            errors++;
            $display("[TB] FAIL idle_no_strobe: got %0d strobes, required 0", strobe_count - start);
        end
    endtask

    task automatic test_single_press;
        int start;
        int n;
        start = strobe_count;
        exp_q.push_back(4'b0011);
        keys_held[2] = 1'b1;
        wait_for_strobe(start, 10 * FRAME, n);
        checks++;
        if (strobe_count == start) begin
            errors++;
            $display("[TB] FAIL press3_timeout: got no strobe, required one within %0d clocks", LAT_LIMIT);
        end
        checks++;
        if (n > LAT_LIMIT) begin
            errors++;
            $display("[TB] FAIL press3_latency: got %0d clocks, required <= %0d", n, LAT_LIMIT);
        end
        step(10 * FRAME - n);
        keys_held = '0;
        step(4 * FRAME);
        checks++;
        if (strobe_count != start + 1) begin
            errors++;
            $display("[TB] FAIL press3_count: got %0d strobes, required 1", strobe_count - start);
        end
    endtask

    task automatic test_two_keys;
        int start;
        int n;
        start = strobe_count;
        exp_q.push_back(4'b0001);
        keys_held[0] = 1'b1;
        step(3 * FRAME);
        keys_held = '0;
        step(3 * FRAME);
        checks++;
        if (strobe_count != start + 1) begin
            errors++;
            $display("[TB] FAIL key1_strobe: got %0d strobes, required 1", strobe_count - start);
        end
        exp_q.push_back(4'b1010);
        keys_held[9] = 1'b1;
        wait_for_strobe(start + 1, 10 * FRAME, n);
        checks++;
        if (strobe_count != start + 2) begin
            errors++;
            $display("[TB] FAIL star_strobe: got %0d strobes, required 2", strobe_count - start);
        end
        keys_held = '0;
        step(4 * FRAME);
    endtask

    task automatic test_bounce;
        int start;
        start = strobe_count;
        for (int i = 0; i < 4; i++) begin
            keys_held[4] = 1'b1;
            step(FRAME);
            keys_held[4] = 1'b0;
            step(FRAME);
        end
        step(2 * FRAME);
        checks++;
        if (strobe_count != start) begin
            errors++;
            $display("[TB] FAIL bounce_no_strobe: got %0d strobes, required 0", strobe_count - start);
        end
        exp_q.push_back(4'b0101);
        keys_held[4] = 1'b1;
        step(FRAME + 4);
        checks++;
        if (strobe_count != start) begin
            errors++;
            $display("[TB] FAIL bounce_redebounce: got %0d strobes after one frame, required 0",
                     strobe_count - start);
        end
        step(3 * FRAME);
        checks++;
        if (strobe_count != start + 1) begin
            errors++;
            $display("[TB] FAIL bounce_then_hold: got %0d strobes, required 1", strobe_count - start);
        end
        keys_held = '0;
        step(4 * FRAME);
    endtask

    task automatic test_multi_key;
        int start;
        int n;
        start = strobe_count;
        keys_held[1] = 1'b1;
        keys_held[7] = 1'b1;
        step(5 * FRAME);
        checks++;
        if (strobe_count != start) begin
            errors++;
            $display("[TB] FAIL multi_no_strobe: got %0d strobes, required 0", strobe_count - start);
        end
        exp_q.push_back(4'b0010);
        keys_held[7] = 1'b0;
        wait_for_strobe(start, 10 * FRAME, n);
        checks++;
        if ((strobe_count != start + 1) || (n > LAT_LIMIT)) begin
            errors++;
            $display("[TB] FAIL multi_release: got %0d strobes after %0d clocks, required 1 within %0d",
                     strobe_count - start, n, LAT_LIMIT);
        end
        step(3 * FRAME);
        keys_held = '0;
        step(4 * FRAME);
    endtask

    task automatic test_reset_mid_press;
        int start;
        int n;
        start = strobe_count;
        exp_q.push_back(4'b1100);
        keys_held[11] = 1'b1;
        wait_for_strobe(start, 10 * FRAME, n);
        checks++;
        if (strobe_count != start + 1) begin
            errors++;
            $display("[TB] FAIL hash_first: got %0d strobes, required 1", strobe_count - start);
        end
        step(SCAN_DIV + 1);
        rst = 1'b0;
        #1;
        checks++;
        if ((col_out !== 3'b110) || (key_valid !== 1'b0) || (keypad_out !== 4'b0000)) begin
            errors++;
            $display("[TB] FAIL async_reset: got col=%b valid=%b out=%b, required 110/0/0000",
                     col_out, key_valid, keypad_out);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        exp_q.push_back(4'b1100);
        wait_for_strobe(start + 1, 10 * FRAME, n);
        checks++;
        if ((strobe_count != start + 2) || (n < DEBOUNCE * FRAME - 1) || (n > LAT_LIMIT)) begin
            errors++;
            $display("[TB] FAIL hash_redebounce: got %0d strobes after %0d clocks, required 2 within %0d..%0d",
                     strobe_count - start, n, DEBOUNCE * FRAME - 1, LAT_LIMIT);
        end
        step(3 * FRAME);
        keys_held = '0;
        step(4 * FRAME);
        checks++;
        if (strobe_count != start + 2) begin
            errors++;
            $display("[TB] FAIL hash_total: got %0d strobes, required 2", strobe_count - start);
        end
    endtask

    // Runs every scenario in order, then confirms the scoreboard drained.
    initial begin
        checks       = 0;
        errors       = 0;
        strobe_count = 0;
        test_reset();
        test_idle_scan();
        test_single_press();
        test_two_keys();
        test_bounce();
        test_multi_key();
        test_reset_mid_press();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending strobes, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
